// File: rtl/tc_sram_initiator_pkg.sv
// Shared types and helpers for the tc_sram initiator: response entry layout and range check.
package tc_sram_initiator_pkg;

    localparam int unsigned DefaultDataWidth = 32;

    typedef struct packed {
        logic [DefaultDataWidth-1:0] data;
        logic                        err;
    } rsp_t;

    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned num_words);
        return addr < num_words;
    endfunction

endpackage

// File: rtl/tc_sram_rsp_fifo.sv
// Synchronous response FIFO holding read results until the downstream consumer takes them.
module tc_sram_rsp_fifo
    import tc_sram_initiator_pkg::*;
#(
    parameter int unsigned Depth = 2,
    parameter type entry_t = rsp_t
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output entry_t pop_data,
    output logic   empty
);

    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntWidth = $clog2(Depth + 1);

    entry_t              mem [Depth];
    logic [PtrWidth-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CntWidth-1:0] count_reg;
    logic                full, do_push, do_pop;

    function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] ptr);
        return (ptr == PtrWidth'(Depth - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign full     = (count_reg == CntWidth'(Depth));
    assign empty    = (count_reg == '0);
    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign do_push  = push & (~full | pop);
    assign do_pop   = pop & ~empty;
    assign pop_data = empty ? '0 : mem[rd_ptr_reg];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= next_ptr(wr_ptr_reg);
            if (do_pop)  rd_ptr_reg <= next_ptr(rd_ptr_reg);
            count_reg <= count_reg + CntWidth'(do_push) - CntWidth'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr_reg] <= push_data;
    end

endmodule

// File: rtl/tc_sram_initiator.sv
// Stream-to-SRAM initiator: issues SRAM requests from a valid/ready stream and returns
// read data through a credit-guarded response buffer so backpressure never drops data.
module tc_sram_initiator
    import tc_sram_initiator_pkg::*;
#(
    parameter int unsigned NumWords  = 1024,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned ByteWidth = 8,
    parameter int unsigned Latency   = 1,
    parameter int unsigned RespDepth = Latency + 1,
    localparam int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
    localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_we_i,
    input  logic [31:0]          req_addr_i,
    input  logic [DataWidth-1:0] req_wdata_i,
    input  logic [BeWidth-1:0]   req_be_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DataWidth-1:0] rsp_data_o,
    output logic                 rsp_err_o,
    output logic                 sram_req_o,
    output logic                 sram_we_o,
    output logic [AddrWidth-1:0] sram_addr_o,
    output logic [DataWidth-1:0] sram_wdata_o,
    output logic [BeWidth-1:0]   sram_be_o,
    input  logic [DataWidth-1:0] sram_rdata_i
);

    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic                 err;
    } entry_t;

    localparam int unsigned CreditWidth = $clog2(RespDepth + 1);

    logic [CreditWidth-1:0] credits_reg, credits_next;
    logic   in_range, pop, read_accept;
    logic   exit_valid, exit_err, fifo_empty;
    entry_t push_data, head;

    assign in_range    = addr_in_range(req_addr_i, NumWords);
    assign pop         = rsp_valid_o & rsp_ready_i;
    // Every accepted read owns a buffer slot from issue until it is popped.
    assign req_ready_o = req_we_i | (credits_reg < CreditWidth'(RespDepth)) | pop;
    assign read_accept = req_valid_i & ~req_we_i & req_ready_o;

    assign sram_req_o   = req_valid_i & req_ready_o & in_range;
    assign sram_we_o    = req_we_i;
    assign sram_addr_o  = req_addr_i[AddrWidth-1:0];
    assign sram_wdata_o = req_wdata_i;
    assign sram_be_o    = req_be_i;

    always_comb begin
        credits_next = credits_reg + CreditWidth'(read_accept) - CreditWidth'(pop);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) credits_reg <= '0;
        else       credits_reg <= credits_next;
    end

    // Pending pipe tracks each read until its SRAM data is valid.
    generate
        if (Latency > 0) begin : g_pipe
            logic [Latency-1:0] valid_reg, err_reg;
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    valid_reg <= '0;
                    err_reg   <= '0;
                end else begin
                    valid_reg[0] <= read_accept;
                    err_reg[0]   <= ~in_range;
                    for (int i = 1; i < Latency; i++) begin
                        valid_reg[i] <= valid_reg[i-1];
                        err_reg[i]   <= err_reg[i-1];
                    end
                end
            end
            assign exit_valid = valid_reg[Latency-1];
            assign exit_err   = err_reg[Latency-1];
        end else begin : g_direct
            assign exit_valid = read_accept;
            assign exit_err   = ~in_range;
        end
    endgenerate

    assign push_data = '{data: (exit_err ? '0 : sram_rdata_i), err: exit_err};

    tc_sram_rsp_fifo #(
        .Depth   (RespDepth),
        .entry_t (entry_t)
    ) u_rsp_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push      (exit_valid),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (head),
        .empty     (fifo_empty)
    );

    assign rsp_valid_o = ~fifo_empty;
    assign rsp_data_o  = head.data;
    assign rsp_err_o   = head.err;

endmodule

// File: tb/tb_tc_sram_initiator.sv
// Randomized scoreboard bench for tc_sram_initiator with a behavioural SRAM and reference memory.
module tb_tc_sram_initiator;

    localparam int unsigned NumWords  = 1024;
    localparam int unsigned RespDepth = 2;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [31:0] req_addr_i = '0;
    logic [31:0] req_wdata_i = '0;
    logic [3:0]  req_be_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b1;
    logic [31:0] rsp_data_o;
    logic        rsp_err_o;
    logic        sram_req_o;
    logic        sram_we_o;
    logic [9:0]  sram_addr_o;
    logic [31:0] sram_wdata_o;
    logic [3:0]  sram_be_o;
    logic [31:0] sram_rdata_i = '0;

    tc_sram_initiator #(
        .NumWords(NumWords), .DataWidth(32), .ByteWidth(8), .Latency(1), .RespDepth(RespDepth)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_be_i(req_be_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
        .rsp_err_o(rsp_err_o),
        .sram_req_o(sram_req_o), .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
        .sram_wdata_o(sram_wdata_o), .sram_be_o(sram_be_o), .sram_rdata_i(sram_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] sram_mem [NumWords];
    logic [31:0] ref_mem  [NumWords];
    int          checks = 0;
    int          errors = 0;
    int          pops = 0;
    int          rsp_mode = 0;   // 0: always ready, 1: never ready, 2: random
    logic        stall_prev = 1'b0;
    logic [32:0] stall_payload = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Behavioural single-port SRAM, one cycle read latency.
    always @(posedge clk_i) begin
        if (sram_req_o) begin
            if (sram_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (sram_be_o[b]) sram_mem[sram_addr_o][8*b +: 8] <= sram_wdata_o[8*b +: 8];
            end else begin
                sram_rdata_i <= sram_mem[sram_addr_o];
            end
        end
    end

    always @(posedge clk_i) begin
        #1;
        case (rsp_mode)
            0:       rsp_ready_i = 1'b1;
            1:       rsp_ready_i = 1'b0;
            default: rsp_ready_i = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Monitor: pops the scoreboard on every response handshake.
    always @(negedge clk_i) begin
        if (rst_i) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("rsp_hold_valid", 64'(rsp_valid_o), 64'd1);
                check("rsp_hold_payload", 64'({rsp_err_o, rsp_data_o}), 64'(stall_payload));
            end
            if (rsp_valid_o && rsp_ready_i) begin
                check("rsp_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("rsp_data", 64'(rsp_data_o), 64'(mon_e.data));
                    check("rsp_err", 64'(rsp_err_o), 64'(mon_e.err));
                    pops++;
                end
            end
            stall_prev    = rsp_valid_o && !rsp_ready_i;
            stall_payload = {rsp_err_o, rsp_data_o};
        end
    end

    task automatic model_accept(input logic we, input logic [31:0] addr,
                                input logic [31:0] data, input logic [3:0] be);
        exp_t e;
        if (we) begin
            if (addr < NumWords)
                for (int b = 0; b < 4; b++)
                    if (be[b]) ref_mem[addr][8*b +: 8] = data[8*b +: 8];
        end else begin
            if (addr < NumWords) begin
                e.data = ref_mem[addr];
                e.err  = 1'b0;
            end else begin
                e.data = '0;
                e.err  = 1'b1;
            end
            exp_q.push_back(e);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the last attempted cycle.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] be, input int max_wait, output logic acc);
        logic [9:0] low;
        low = addr[9:0];
        req_valid_i = 1'b1; req_we_i = we; req_addr_i = addr; req_wdata_i = data; req_be_i = be;
        acc = 1'b0;
        for (int w = 0; w <= max_wait && !acc; w++) begin
            @(negedge clk_i);
            if (req_ready_o) begin
                acc = 1'b1;
                check("sram_req", 64'(sram_req_o), 64'(addr < NumWords));
                if (addr < NumWords) begin
                    check("sram_addr", 64'(sram_addr_o), 64'(low));
                    check("sram_we", 64'(sram_we_o), 64'(we));
                end
                model_accept(we, addr, data, be);
            end
            @(posedge clk_i); #1;
        end
        req_valid_i = 1'b0;
    endtask

    task automatic issue_b(input logic we, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] be);
        logic acc;
        issue(we, addr, data, be, 60, acc);
        check("req_accept_timeout", 64'(acc), 64'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk_i); #1; end
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) idle(1);
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic        acc;
        int          n_acc;
        int          pops0;
        logic [31:0] pend_addr[$];
        logic [31:0] a;
        logic [31:0] v;

        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        acc;
        int          n_acc;
        int          pops0;
        logic [31:0] pend_addr[$];
        logic [31:0] a;
        logic [31:0] v;

        for (int i = 0; i < NumWords; i++) begin
            v = $urandom;
            sram_mem[i] = v;
            ref_mem[i]  = v;
        end
        repeat (3) @(posedge clk_i);
        #1;
        check("reset_rsp_valid", 64'(rsp_valid_o), 64'd0);
        check("reset_rsp_err", 64'(rsp_err_o), 64'd0);
        check("reset_rsp_data", 64'(rsp_data_o), 64'd0);
        check("reset_sram_req", 64'(sram_req_o), 64'd0);
        check("reset_req_ready", 64'(req_ready_o), 64'd1);
        rst_i = 1'b0;
        idle(1);

        // Full write then read back, with exact response timing.
        issue_b(1'b1, 32'd5, 32'hDEADBEEF, 4'hF);
        issue_b(1'b0, 32'd5, 32'h0, 4'h0);
        @(negedge clk_i);
        check("lat_not_early", 64'(rsp_valid_o), 64'd0);
        @(negedge clk_i);
        check("lat_on_time", 64'(rsp_valid_o), 64'd1);
        @(posedge clk_i); #1;
        drain();

        // Partial byte write.
        issue_b(1'b1, 32'd7, 32'h11223344, 4'hF);
        issue_b(1'b1, 32'd7, 32'h0000AB00, 4'b0010);
        issue_b(1'b0, 32'd7, 32'h0, 4'h0);
        drain();

        // Sixteen back-to-back reads at full rate.
        pops0 = pops;
        for (int k = 0; k < 16; k++) begin
            issue(1'b0, 32'($urandom_range(0, NumWords - 1)), 32'h0, 4'h0, 0, acc);
            check("b2b_ready", 64'(acc), 64'd1);
        end
        idle(2);
        check("b2b_rate", 64'(pops - pops0), 64'd16);
        drain();

        // Backpressure: only RespDepth reads fit.
        rsp_mode = 1; rsp_ready_i = 1'b0;
        n_acc = 0;
        for (int k = 0; k < 10; k++) begin
            a = 32'($urandom_range(0, NumWords - 1));
            issue(1'b0, a, 32'h0, 4'h0, 0, acc);
            if (acc) n_acc++;
            else pend_addr.push_back(a);
        end
        check("bp_accepted", 64'(n_acc), 64'(RespDepth));
        req_we_i = 1'b0;
        @(negedge clk_i);
        check("bp_read_ready_low", 64'(req_ready_o), 64'd0);
        req_we_i = 1'b1;
        #1;
        check("bp_write_ready", 64'(req_ready_o), 64'd1);
        req_we_i = 1'b0;
        @(posedge clk_i); #1;
        rsp_mode = 2;
        while (pend_addr.size() != 0) issue_b(1'b0, pend_addr.pop_front(), 32'h0, 4'h0);
        drain();

        // Out-of-range accesses interleaved with neighbours.
        rsp_mode = 0;
        issue_b(1'b1, NumWords + 32'd5, 32'hCAFEF00D, 4'hF);
        issue_b(1'b0, 32'd10, 32'h0, 4'h0);
        issue_b(1'b0, NumWords, 32'h0, 4'h0);
        issue_b(1'b0, 32'd11, 32'h0, 4'h0);
        issue_b(1'b0, 32'hFFFF_FFF0, 32'h0, 4'h0);
        issue_b(1'b0, 32'd5, 32'h0, 4'h0);
        drain();

        // Reset with reads in flight.
        rsp_mode = 1; rsp_ready_i = 1'b0;
        issue_b(1'b0, 32'd20, 32'h0, 4'h0);
        issue_b(1'b0, 32'd21, 32'h0, 4'h0);
        rst_i = 1'b1;
        #1;
        exp_q.delete();
        check("midrst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        check("midrst_rsp_data", 64'(rsp_data_o), 64'd0);
        check("midrst_sram_req", 64'(sram_req_o), 64'd0);
        check("midrst_credits", 64'(req_ready_o), 64'd1);
        idle(2);
        rst_i = 1'b0;
        rsp_mode = 0; rsp_ready_i = 1'b1;
        idle(2);
        issue_b(1'b1, 32'd21, 32'h5A5A1234, 4'hF);
        issue_b(1'b0, 32'd21, 32'h0, 4'h0);
        drain();

        // Random mixed traffic.
        rsp_mode = 2;
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 9) == 0) a = NumWords + 32'($urandom_range(0, 64));
            else a = 32'($urandom_range(0, 15));
            issue_b(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        rsp_mode = 0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
